// File: rtl/instruction_prefetch_queue_pkg.sv
// Shared types and constants for the instruction prefetch path:
// FSM encoding, queue entry layout and address helpers.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_INST = 32'h0;

    localparam int unsigned FETCH_DEPTH_DEFAULT = 4;
    localparam int unsigned FETCH_PTR_W         = $clog2(FETCH_DEPTH_DEFAULT);

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc_add4;
    } fetch_entry_t;

    localparam fetch_entry_t EMPTY_ENTRY = '{inst: NOP_INST, pc_add4: 32'h0};

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/instruction_prefetch_queue_fifo.sv
// DEPTH-entry queue of {instruction, PC+4} pairs with flush.
// Head read is combinational from storage; an empty queue presents a nop.
module fetch_queue_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = FETCH_DEPTH_DEFAULT
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      flush_i,
    input  logic                      push_i,
    input  logic                      pop_i,
    input  fetch_entry_t              push_entry_i,
    output fetch_entry_t              head_entry_o,
    output logic                      head_valid_o,
    output logic [$clog2(DEPTH):0]    count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        do_push  = push_i & ~flush_i;
        do_pop   = pop_i & ~flush_i & (count_q != '0);
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_push) begin
            mem_q[wr_ptr_q] <= push_entry_i;
        end
    end

    assign head_valid_o = (count_q != '0);
    assign head_entry_o = head_valid_o ? mem_q[rd_ptr_q] : EMPTY_ENTRY;
    assign count_o      = count_q;

endmodule

// File: rtl/instruction_prefetch_queue.sv
// Fetch-side prefetch buffer: one outstanding req/ack memory request,
// queued {instruction, PC+4} for decode, flush-and-restart on redirect.
module instruction_prefetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH    = FETCH_DEPTH_DEFAULT,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        RedirectValid,
    input  logic [31:0] RedirectAddr,
    input  logic        DecodeStall,
    output logic        InstValid,
    output logic [31:0] InstOut,
    output logic [31:0] PCAddrAdd4Out,
    output logic        IMemReq,
    output logic [31:0] IMemAddr,
    input  logic        IMemAck,
    input  logic [31:0] IMemData
);

    localparam int unsigned    PTR_W     = $clog2(DEPTH);
    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(DEPTH);

    fetch_state_e   state_q, state_d;
    logic [31:0]    fetch_pc_q, fetch_pc_d;
    logic [31:0]    req_addr_q, req_addr_d;

    logic           q_push;
    logic           q_pop;
    logic           q_valid;
    logic [PTR_W:0] q_count;
    logic [PTR_W:0] count_after_ack;
    fetch_entry_t   q_head;
    fetch_entry_t   q_push_entry;

    assign q_pop           = q_valid & ~DecodeStall & ~RedirectValid;
    assign count_after_ack = q_count + (PTR_W+1)'(1) - (PTR_W+1)'(q_pop);
    assign q_push_entry    = '{inst: IMemData, pc_add4: req_addr_q + 32'd4};

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_addr_d = req_addr_q;
        q_push     = 1'b0;
        if (RedirectValid) begin
            fetch_pc_d = word_align(RedirectAddr);
        end
        unique case (state_q)
            IDLE: begin
                if (!RedirectValid && (q_count < DEPTH_CNT)) begin
                    state_d    = REQ;
                    req_addr_d = fetch_pc_q;
                end
            end
            REQ: begin
                if (RedirectValid) begin
                    state_d = IMemAck ? IDLE : DROP;
                end else if (IMemAck) begin
                    q_push     = 1'b1;
                    fetch_pc_d = fetch_pc_q + 32'd4;
                    // Back-to-back issue needs a slot left after this push (and any pop).
                    if (count_after_ack < DEPTH_CNT) begin
                        req_addr_d = fetch_pc_q + 32'd4;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DROP: begin
                if (IMemAck) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            req_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_addr_q <= req_addr_d;
        end
    end

    fetch_queue_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i        (Clk),
        .rst_i        (Rst),
        .flush_i      (RedirectValid),
        .push_i       (q_push),
        .pop_i        (q_pop),
        .push_entry_i (q_push_entry),
        .head_entry_o (q_head),
        .head_valid_o (q_valid),
        .count_o      (q_count)
    );

    assign IMemReq       = (state_q != IDLE);
    assign IMemAddr      = req_addr_q;
    assign InstValid     = q_valid;
    assign InstOut       = q_head.inst;
    assign PCAddrAdd4Out = q_head.pc_add4;

endmodule
